// File: rtl/link_arbiter.sv
// Two-requester arbiter feeding a 4-phase req/ack link slave, one byte in flight.
// Ties are broken by a pointer that favours the requester not served last.
module link_arbiter #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_valid,
  input  logic [7:0] a_data,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_data,
  output logic       b_ready,
  output logic       req,
  output logic [7:0] data,
  input  logic       ack,
  output logic       done,
  output logic [7:0] last_byte,
  output logic       last_src,
  output logic       err,
  output logic [7:0] xfer_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state_reg;
  logic       prio_reg;
  logic       cur_src_reg;
  logic [7:0] tmo_cnt_reg;
  logic       req_reg;
  logic [7:0] data_reg;
  logic       done_reg;
  logic       err_reg;
  logic [7:0] last_byte_reg;
  logic       last_src_reg;
  logic [7:0] xfer_cnt_reg;

  logic idle_open;
  logic a_grant;
  logic b_grant;

  always_comb begin
    idle_open = (state_reg == S_IDLE) && !rst;
    b_grant   = b_valid && (!a_valid || prio_reg);
    a_grant   = a_valid && !b_grant;
  end

  assign a_ready   = idle_open && a_grant;
  assign b_ready   = idle_open && b_grant;
  assign req       = req_reg;
  assign data      = data_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign last_byte = last_byte_reg;
  assign last_src  = last_src_reg;
  assign xfer_cnt  = xfer_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      prio_reg      <= 1'b0;
      cur_src_reg   <= 1'b0;
      tmo_cnt_reg   <= 8'd0;
      req_reg       <= 1'b0;
      data_reg      <= 8'd0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      last_byte_reg <= 8'd0;
      last_src_reg  <= 1'b0;
      xfer_cnt_reg  <= 8'd0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          // ack is deliberately not looked at here
          if (a_ready || b_ready) begin
            data_reg    <= b_ready ? b_data : a_data;
            cur_src_reg <= b_ready;
            tmo_cnt_reg <= 8'd0;
            req_reg     <= 1'b1;
            state_reg   <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack) begin
            req_reg   <= 1'b0;
            state_reg <= S_DROP;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            req_reg   <= 1'b0;
            err_reg   <= 1'b1;
            prio_reg  <= ~cur_src_reg;
            state_reg <= S_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
          end
        end
        S_DROP: begin
          if (!ack) begin
            done_reg      <= 1'b1;
            last_byte_reg <= data_reg;
            last_src_reg  <= cur_src_reg;
            xfer_cnt_reg  <= xfer_cnt_reg + 8'd1;
            prio_reg      <= ~cur_src_reg;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          req_reg   <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_link_arbiter.sv
// Directed bench for link_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_link_arbiter;

  localparam int ACK_TIMEOUT = 15;

  logic       clk;
  logic       rst;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_ready;
  logic       req;
  logic [7:0] data;
  logic       ack;
  logic       done;
  logic [7:0] last_byte;
  logic       last_src;
  logic       err;
  logic [7:0] xfer_cnt;

  link_arbiter #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .req(req), .data(data), .ack(ack),
    .done(done), .last_byte(last_byte), .last_src(last_src),
    .err(err), .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Requester queues and slave behaviour, driven on negedges
  logic [7:0] a_q[$];
  logic [7:0] b_q[$];
  bit a_took = 0, b_took = 0;
  int slave_mode = 0;   // 0 = responds after slave_delay, 1 = never acks, 2 = ack stuck high
  int slave_delay = 0;
  int slave_cnt = 0;

  initial begin
    a_valid = 0; a_data = 0; b_valid = 0; b_data = 0; ack = 0;
    forever begin
      @(negedge clk);
      if (a_took) void'(a_q.pop_front());
      if (b_took) void'(b_q.pop_front());
      a_valid = (a_q.size() > 0);
      if (a_valid) a_data = a_q[0];
      b_valid = (b_q.size() > 0);
      if (b_valid) b_data = b_q[0];
      case (slave_mode)
        0: begin
          if (req && !ack) begin
            if (slave_cnt >= slave_delay) ack = 1'b1;
            else slave_cnt++;
          end else if (!req && ack) begin
            ack = 1'b0;
          end
          if (!req) slave_cnt = 0;
        end
        1: ack = 1'b0;
        default: ack = 1'b1;
      endcase
    end
  end

  // Reference model: a byte is either absent, waiting for ack, or waiting for ack release
  bit       m_busy, m_acked, m_turn, m_src, m_last_src, m_done, m_err;
  int       m_wait, m_count;
  bit [7:0] m_data, m_last_byte;

  function automatic bit b_wins(input bit av, input bit bv, input bit turn);
    if (av && bv) return turn;
    return bv;
  endfunction

  function automatic bit exp_a_ready();
    return !rst && !m_busy && a_valid && !b_wins(a_valid, b_valid, m_turn);
  endfunction

  function automatic bit exp_b_ready();
    return !rst && !m_busy && b_valid && b_wins(a_valid, b_valid, m_turn);
  endfunction

  always @(posedge clk) begin
    bit ga, gb;
    ga = exp_a_ready();
    gb = exp_b_ready();
    m_done = 0;
    m_err = 0;
    if (rst) begin
      m_busy = 0; m_acked = 0; m_wait = 0; m_data = 0; m_turn = 0;
      m_last_byte = 0; m_last_src = 0; m_count = 0;
    end else if (!m_busy) begin
      if (ga || gb) begin
        m_busy = 1; m_acked = 0; m_wait = 0;
        m_src = gb;
        m_data = gb ? b_data : a_data;
      end
    end else if (!m_acked) begin
      if (ack) m_acked = 1;
      else begin
        m_wait++;
        if (m_wait >= ACK_TIMEOUT) begin
          m_busy = 0; m_err = 1; m_turn = !m_src;
        end
      end
    end else if (!ack) begin
      m_busy = 0; m_done = 1;
      m_last_byte = m_data; m_last_src = m_src;
      m_count = (m_count + 1) % 256;
      m_turn = !m_src;
    end
  end

  // Compare process plus event counters
  bit compare_on = 0;
  int n_done = 0, n_err = 0, n_req_rise = 0, n_req_high = 0, n_a_ready = 0;
  bit prev_req = 0;
  logic [7:0] done_log[$];
  bit src_log[$];

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (compare_on) begin
        chk("a_ready", a_ready, exp_a_ready());
        chk("b_ready", b_ready, exp_b_ready());
        chk("ready_exclusive", a_ready & b_ready, 0);
        chk("req", req, m_busy && !m_acked);
        chk("data", data, m_data);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("last_byte", last_byte, m_last_byte);
        chk("last_src", last_src, m_last_src);
        chk("xfer_cnt", xfer_cnt, m_count);
        if (req && !prev_req) n_req_rise++;
        if (req) n_req_high++;
        if (done) begin
          n_done++;
          done_log.push_back(last_byte);
          src_log.push_back(last_src);
        end
        if (err) n_err++;
        if (a_ready) n_a_ready++;
        prev_req = req;
      end
      a_took = a_valid && a_ready;
      b_took = b_valid && b_ready;
    end
  end

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    #3;
    chk("wait_done_in_budget", n_done >= target, 1);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1;
    repeat (n) @(negedge clk);
    rst = 0;
  endtask

  int s_done, s_rise, s_high, s_err, s_ar, k;

  initial begin
    rst = 1;
    repeat (3) @(negedge clk);
    compare_on = 1;
    rst = 0;
    #3;
    chk("reset_req", req, 0);
    chk("reset_data", data, 0);
    chk("reset_xfer_cnt", xfer_cnt, 0);
    chk("reset_last_byte", last_byte, 0);

    // Single A byte, slave acks two cycles after req
    s_done = n_done; s_rise = n_req_rise;
    slave_mode = 0; slave_delay = 2;
    a_q.push_back(8'hA5);
    wait_done(s_done + 1, 100);
    repeat (5) @(negedge clk);
    #3;
    chk("single_done_count", n_done - s_done, 1);
    chk("single_req_rises", n_req_rise - s_rise, 1);
    chk("single_last_byte", last_byte, 8'hA5);
    chk("single_last_src", last_src, 0);
    chk("single_xfer_cnt", xfer_cnt, 1);

    // Both requesters pending, prompt slave: strict alternation
    do_reset(2);
    slave_delay = 0;
    done_log.delete(); src_log.delete();
    s_done = n_done;
    a_q.push_back(8'h11); a_q.push_back(8'h11);
    b_q.push_back(8'h22); b_q.push_back(8'h22);
    wait_done(s_done + 4, 200);
    chk("alt_log_size", done_log.size(), 4);
    if (done_log.size() >= 4) begin
      chk("alt_byte0", done_log[0], 8'h11);
      chk("alt_byte1", done_log[1], 8'h22);
      chk("alt_byte2", done_log[2], 8'h11);
      chk("alt_byte3", done_log[3], 8'h22);
      chk("alt_src1", src_log[1], 1);
    end
    chk("alt_xfer_cnt", xfer_cnt, 4);

    // Slave never acks: timeout after exactly ACK_TIMEOUT req cycles
    do_reset(2);
    slave_mode = 1;
    s_done = n_done; s_high = n_req_high; s_err = n_err;
    a_q.push_back(8'h42);
    k = 0;
    while (n_err == s_err && k < 100) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    #3;
    chk("tmo_req_high_cycles", n_req_high - s_high, ACK_TIMEOUT);
    chk("tmo_err_count", n_err - s_err, 1);
    chk("tmo_done_count", n_done - s_done, 0);
    chk("tmo_xfer_cnt", xfer_cnt, 0);
    slave_mode = 0;
    done_log.delete(); src_log.delete();
    s_done = n_done;
    a_q.push_back(8'h77); b_q.push_back(8'h88);
    wait_done(s_done + 2, 100);
    if (done_log.size() >= 2) begin
      chk("tmo_next_src", src_log[0], 1);
      chk("tmo_next_byte", done_log[0], 8'h88);
      chk("tmo_then_byte", done_log[1], 8'h77);
    end

    // Reset asserted for three cycles while a byte sits in REQ
    slave_mode = 1;
    a_q.push_back(8'h5A);
    k = 0;
    while (!req && k < 50) begin @(negedge clk); k++; end
    chk("rst_mid_saw_req", req, 1);
    chk("rst_mid_data", data, 8'h5A);
    repeat (2) @(negedge clk);
    s_done = n_done; s_err = n_err;
    rst = 1;
    @(negedge clk);
    #3;
    chk("rst_mid_req", req, 0);
    chk("rst_mid_data_cleared", data, 0);
    chk("rst_mid_xfer_cnt", xfer_cnt, 0);
    chk("rst_mid_a_ready", a_ready, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_mid_no_done", n_done - s_done, 0);
    chk("rst_mid_no_err", n_err - s_err, 0);
    slave_mode = 0;
    a_q.push_back(8'h3C);
    wait_done(s_done + 1, 100);
    chk("rst_after_last_byte", last_byte, 8'h3C);
    chk("rst_after_xfer_cnt", xfer_cnt, 1);

    // ack held high in IDLE is ignored; a byte is still accepted
    s_rise = n_req_rise; s_done = n_done;
    slave_mode = 2;
    repeat (4) @(negedge clk);
    chk("ack_idle_no_req", n_req_rise - s_rise, 0);
    a_q.push_back(8'hC3);
    repeat (4) @(negedge clk);
    slave_mode = 0;
    wait_done(s_done + 1, 100);
    chk("ack_idle_last_byte", last_byte, 8'hC3);
    chk("ack_idle_xfer_cnt", xfer_cnt, 2);

    // 256 B-only transfers wrap the counter
    do_reset(2);
    s_done = n_done; s_ar = n_a_ready;
    for (int i = 0; i < 256; i++) b_q.push_back(8'(i));
    wait_done(s_done + 256, 1500);
    chk("wrap_done_count", n_done - s_done, 256);
    chk("wrap_xfer_cnt", xfer_cnt, 0);
    chk("wrap_a_ready_never", n_a_ready - s_ar, 0);
    chk("wrap_last_byte", last_byte, 8'hFF);
    chk("wrap_last_src", last_src, 1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/link_arbiter.md
LINK_ARBITER -- requirements
Module: link_arbiter

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15: max cycles spent in REQ waiting for ack before abort (range 1-255).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 a_valid  input  1  requester A has a byte pending.
REQ-005 a_data  input  8  requester A byte.
REQ-006 a_ready  output  1  A's byte accepted this cycle (combinational).
REQ-007 b_valid  input  1  requester B has a byte pending.
REQ-008 b_data  input  8  requester B byte.
REQ-009 b_ready  output  1  B's byte accepted this cycle (combinational).
REQ-010 req  output  1  4-phase request to the shared link slave.
REQ-011 data  output  8  byte presented to the slave; held stable while req=1.
REQ-012 ack  input  1  4-phase acknowledge from the slave.
REQ-013 done  output  1  one-cycle pulse per completed transfer.
REQ-014 last_byte  output  8  byte of the most recent completed transfer.
REQ-015 last_src  output  1  source of the most recent completed transfer (0=A, 1=B).
REQ-016 err  output  1  one-cycle pulse per ack timeout.
REQ-017 xfer_cnt  output  8  completed-transfer count; wraps 255->0.

Function
REQ-018 FSM states: IDLE, REQ, DROP; a single transfer is in flight at a time.
REQ-019 IDLE grant: only A valid -> A; only B valid -> B; both valid -> requester named by the priority pointer prio (0=A, 1=B).
REQ-020 a_ready/b_ready: high only in IDLE, only for the granted requester, never both in the same cycle.
REQ-021 Accept (valid & ready in IDLE): latch the byte into data and the source into cur_src, then move to REQ; req=1 from the next cycle.
REQ-022 REQ: req=1 and data stable; ack=1 sampled -> DROP with req=0 from the next cycle.
REQ-023 DROP: req=0; ack=0 sampled -> IDLE, and in the same edge: done=1, last_byte<=data, last_src<=cur_src, xfer_cnt+=1, prio<=~cur_src.
REQ-024 Timeout: the REQ cycle counter clears on entering REQ; if ACK_TIMEOUT cycles elapse with ack=0 -> go to IDLE, req=0, err=1 for one cycle, prio<=~cur_src, byte dropped, no done, no count/last_* update.
REQ-025 ack high while in IDLE is ignored; an accept is still allowed.
REQ-026 A new accept may occur in the cycle done is high (back-to-back); minimum cycles per transfer = accept + REQ + DROP = 3 when the slave responds immediately.
REQ-027 The data output and req have no combinational path from ack.
REQ-028 Requesters must hold valid/data until ready; the arbiter never drops an accepted byte except on timeout.

Reset
REQ-029 rst=1 at a posedge -> state IDLE, req=0, data=0, done=0, err=0, last_byte=0, last_src=0, xfer_cnt=0, prio=0 (A first), timeout counter=0.
REQ-030 rst asserted mid-transfer (REQ or DROP) aborts it: req=0 the next cycle, no done, no err.
REQ-031 While rst=1, a_ready=b_ready=0.

Verification
REQ-032 Single A: a_data=8'hA5, slave acks 2 cycles after req -> req rises once, done pulses once, last_byte=A5, last_src=0, xfer_cnt=1.
REQ-033 Both valid continuously, A=8'h11, B=8'h22, prompt slave, 4 transfers -> order A,B,A,B; last_byte sequence 11,22,11,22; xfer_cnt=4.
REQ-034 Slave never acks, ACK_TIMEOUT=15 -> req high exactly 15 cycles, err pulses once, done stays 0, xfer_cnt=0, next grant goes to the other requester.
REQ-035 rst for 3 cycles during REQ with data=8'h5A -> req=0 on the cycle after the rst edge, outputs at their reset values, then a clean transfer of 8'h3C completes with xfer_cnt=1.
REQ-036 256 B-only transfers -> xfer_cnt wraps to 0, done count=256, a_ready never high.
REQ-037 All runs: req never rises while ack=1 in DROP, data never changes while req=1, a_ready&b_ready never both 1.
